// File: rtl/mem_dump_tx.sv
// mem_dump_tx: latches a dword address, snapshots the 64-bit memory word and sends it MSB byte first as 8N1 UART frames.
// Latency: tx falls one cycle after command acceptance; a dump lasts 1 + 80*CLK_DIV cycles (90*CLK_DIV with checksum).
// Backpressure: cmd_ready is high only in IDLE; cmd_valid is ignored while busy, and commands are never queued.
//
// Ports: clk/reset_n (async active-low); cmd_valid/cmd_byte/cmd_ready command handshake;
//        memadr -> memory debug address, mdata <- memory word; tx serial line; busy; done pulse.
// Optional feature: define MEM_DUMP_CHECKSUM_EN to append a 9th frame carrying the XOR of the 8 data bytes.
module mem_dump_tx #(
  parameter int CLK_DIV = 868,
  parameter int N       = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  input  logic [7:0]   cmd_byte,
  output logic         cmd_ready,
  output logic [7:0]   memadr,
  input  logic [N-1:0] mdata,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam logic [3:0] LAST_BYTE = 4'd8;
`else
  localparam logic [3:0] LAST_BYTE = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, FETCH, START, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   shreg;
  logic [7:0]     txbyte;
  logic [7:0]     next_byte;
  logic [3:0]     byte_cnt;
  logic [2:0]     bit_cnt;
  logic [2:0]     bit_nxt;
  logic [DW-1:0]  div_cnt;
  logic           tick;
  logic           last_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]     chk;
`endif

  assign tick      = (div_cnt == '0);
  assign last_byte = (byte_cnt == LAST_BYTE);
  assign bit_nxt   = bit_cnt + 3'd1;

  // Byte to send in the frame about to start; the checksum frame follows the 8 data bytes.
  always_comb begin
    next_byte = shreg[N-1 -: 8];
`ifdef MEM_DUMP_CHECKSUM_EN
    if (byte_cnt == 4'd8) next_byte = chk;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cmd_valid) state_nxt = FETCH;
      FETCH: state_nxt = START;
      START: if (tick) state_nxt = DATA;
      DATA:  if (tick && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:  if (tick) state_nxt = last_byte ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Datapath: tx is registered and always set one edge ahead to the level of the upcoming bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx       <= 1'b1;
      memadr   <= '0;
      done     <= 1'b0;
      shreg    <= '0;
      txbyte   <= '0;
      byte_cnt <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (cmd_valid) memadr <= cmd_byte;
        end
        FETCH: begin
          // Snapshot: later memory writes cannot alter the frame contents.
          shreg    <= mdata;
          byte_cnt <= '0;
          tx       <= 1'b0;
          div_cnt  <= DIV_LOAD;
`ifdef MEM_DUMP_CHECKSUM_EN
          chk      <= '0;
`endif
        end
        START: begin
          if (tick) begin
            txbyte  <= next_byte;
            shreg   <= shreg << 8;
            bit_cnt <= '0;
            div_cnt <= DIV_LOAD;
            tx      <= next_byte[0];
`ifdef MEM_DUMP_CHECKSUM_EN
            if (byte_cnt != 4'd8) chk <= chk ^ next_byte;
`endif
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            div_cnt <= DIV_LOAD;
            if (bit_cnt == 3'd7) begin
              tx <= 1'b1;
            end else begin
              bit_cnt <= bit_nxt;
              tx      <= txbyte[bit_nxt];
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (last_byte) begin
              done <= 1'b1;
              tx   <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
              tx       <= 1'b0;
              div_cnt  <= DIV_LOAD;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_tx.sv
module tb_mem_dump_tx;
  localparam int CD = 4;
  localparam int FL = 10 * CD;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int NFR = 9;
`else
  localparam int NFR = 8;
`endif
  localparam int IEND = 1 + NFR * FL;  // sample index where done must be high
  localparam int L = IEND + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic        cmd_ready;
  logic [7:0]  memadr;
  logic [63:0] mdata;
  logic        tx, busy, done;

  logic [63:0] mem [256];
  bit          ovr = 1'b0;
  int          total = 0;
  int          passed = 0;

  assign mdata = ovr ? '1 : mem[memadr];

  always #5 clk = ~clk;

  mem_dump_tx #(.CLK_DIV(CD), .N(64)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .cmd_ready(cmd_ready), .memadr(memadr), .mdata(mdata),
    .tx(tx), .busy(busy), .done(done)
  );

  // Reference: line level for sample i (i=0 is the cycle after acceptance) given frame bytes fb, byte f at fb[71-8f -: 8].
  function automatic logic model_tx(input logic [71:0] fb, input int i);
    int k, f, p;
    if (i < 1 || i >= IEND) return 1'b1;
    k = i - 1;
    f = k / FL;
    p = (k % FL) / CD;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return fb[63 - 8*f + p];
  endfunction

  function automatic logic [71:0] frame_bytes(input logic [63:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int f = 0; f < 8; f++) x = x ^ w[63-8*f -: 8];
    return {w, x};
  endfunction

  task automatic run_dump(input logic [7:0] addr, input int inj, input bit snap, input string nm);
    logic [63:0] w;
    logic [71:0] fb;
    logic [7:0]  b;
    bit          txs [L];
    bit          dns [L];
    bit          bsy [L];
    int          bad, nd;
    w  = mem[addr];
    fb = frame_bytes(w);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = addr;
    @(posedge clk);
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      if (i == 0) begin
        cmd_valid = 1'b0;
        total++;
        if (memadr !== addr || busy !== 1'b1) $display("FAIL %s accept: memadr=%h busy=%b want %h 1", nm, memadr, busy, addr);
        else passed++;
      end
      if (inj >= 0 && i == inj + 1) cmd_valid = 1'b0;
      if (i == inj) begin cmd_valid = 1'b1; cmd_byte = 8'h07; end
      if (snap && i == 1) ovr = 1'b1;
      txs[i] = tx; dns[i] = done; bsy[i] = busy;
    end
    ovr = 1'b0;
    cmd_valid = 1'b0;

    total++;
    if (memadr !== addr) $display("FAIL %s memadr_hold: got %h want %h", nm, memadr, addr);
    else passed++;

    bad = 0;
    for (int i = 0; i < L; i++) if (txs[i] !== model_tx(fb, i)) bad++;
    total++;
    if (bad != 0) $display("FAIL %s waveform: %0d mismatching cycles, want 0", nm, bad);
    else passed++;

    for (int f = 0; f < NFR; f++) begin
      for (int j = 0; j < 8; j++) b[j] = txs[1 + f*FL + (j+1)*CD + CD/2];
      total++;
      if (b !== fb[71-8*f -: 8] || txs[1 + f*FL + CD/2] !== 1'b0 || txs[1 + f*FL + 9*CD + CD/2] !== 1'b1)
        $display("FAIL %s frame%0d: byte=%h start=%b stop=%b want %h 0 1", nm, f, b,
                 txs[1 + f*FL + CD/2], txs[1 + f*FL + 9*CD + CD/2], fb[71-8*f -: 8]);
      else passed++;
    end

    nd = 0;
    for (int i = 0; i < L; i++) if (dns[i]) nd++;
    total++;
    if (nd != 1 || dns[IEND] !== 1'b1) $display("FAIL %s done: pulses=%0d at_end=%b want 1 1", nm, nd, dns[IEND]);
    else passed++;

    total++;
    if (bsy[IEND-1] !== 1'b1 || bsy[IEND] !== 1'b0) $display("FAIL %s busy_fall: %b%b want 10", nm, bsy[IEND-1], bsy[IEND]);
    else passed++;
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || memadr !== 8'h00 || done !== 1'b0)
      $display("FAIL reset_hold: tx=%b busy=%b rdy=%b memadr=%h done=%b want 1 0 1 00 0", tx, busy, cmd_ready, memadr, done);
    else passed++;
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || cmd_ready !== 1'b1 || memadr !== 8'h00 || done !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL reset_idle: %0d active cycles, want 0", bad);
    else passed++;
  endtask

  task automatic test_single_dump();
    mem[5] = 64'h0123456789ABCDEF;
    run_dump(8'h05, -1, 1'b0, "single");
  endtask

  task automatic test_busy_reject();
    mem[5] = 64'h0123456789ABCDEF;
    run_dump(8'h05, 1 + 2*FL + 3*CD, 1'b0, "busy_reject");
  endtask

  task automatic test_snapshot();
    mem[9] = 64'hA5C3_0F1E_7788_0042;
    run_dump(8'h09, -1, 1'b1, "snapshot");
  endtask

  task automatic test_reset_mid();
    int bad;
    mem[3] = 64'hDEAD_BEEF_CAFE_F00D;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = 8'h03;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    // Advance into the data bits of byte 3 and find a cycle where tx is low so the async rise is observable.
    repeat (3*FL + 2*CD) @(negedge clk);
    for (int i = 0; i < 6*CD && tx !== 1'b0; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || memadr !== 8'h00 || cmd_ready !== 1'b1)
      $display("FAIL reset_mid_async: tx=%b busy=%b memadr=%h rdy=%b want 1 0 00 1", tx, busy, memadr, cmd_ready);
    else passed++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 2*FL; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    total++;
    if (bad != 0) $display("FAIL reset_mid_quiet: %0d active cycles, want 0", bad);
    else passed++;
    mem[2] = {$urandom, $urandom};
    run_dump(8'h02, -1, 1'b0, "after_reset");
  endtask

  task automatic test_checksum_word();
    mem[17] = 64'h1122334455667788;
    run_dump(8'h11, -1, 1'b0, "checksum");
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 3; n++) begin
      a = 8'($urandom_range(0, 255));
      mem[a] = {$urandom, $urandom};
      run_dump(a, -1, 1'b0, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    test_reset();
    test_single_dump();
    test_busy_reject();
    test_snapshot();
    test_reset_mid();
    test_checksum_word();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
